// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks microsteps of the current opcode through an external
// microcode ROM. Optional single-step gating is enabled by MICROCODE_SEQUENCER_SINGLE_STEP_EN.
module microcode_sequencer #(
    parameter logic [31:0] IDLE_CW = 32'h17FF58FF,
    parameter int          SR_BIT  = 28,
    parameter int          HLT_BIT = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  opcode,
    input  logic [3:0]  flags,
    input  logic [31:0] urom_data,
    input  logic        resume,
`ifdef MICROCODE_SEQUENCER_SINGLE_STEP_EN
    input  logic        step_req,
`endif
    output logic [14:0] uaddr,
    output logic [31:0] control_word,
    output logic        ctrlen,
    output logic [2:0]  step,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Sequencing bits are consumed here and never reach the CPU.
    localparam logic [31:0] SEQ_MASK  = (32'd1 << SR_BIT) | (32'd1 << HLT_BIT);
    localparam logic [31:0] KEEP_MASK = ~SEQ_MASK;

    state_t     state_q, state_d;
    logic [2:0] step_q,  step_d;
    logic       fault_q, fault_d;
    logic       halted_q, halted_d;
    logic       ctrlen_q, ctrlen_d;
    logic       advance;

`ifdef MICROCODE_SEQUENCER_SINGLE_STEP_EN
    assign advance = step_req;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fault_d = fault_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                step_d  = 3'd0;
            end
            ST_RUN: begin
                if (advance) begin
                    if (urom_data[HLT_BIT]) begin
                        state_d = ST_HALT;
                        step_d  = 3'd0;
                    end else if (urom_data[SR_BIT]) begin
                        step_d = 3'd0;
                    end else if (step_q == 3'd7) begin
                        // Ran off the end of the step space without an SR word.
                        step_d  = 3'd0;
                        fault_d = 1'b1;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                    step_d  = 3'd0;
                end
            end
            default: begin
                state_d = ST_INIT;
                step_d  = 3'd0;
            end
        endcase
        halted_d = (state_d == ST_HALT);
        ctrlen_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            step_q   <= 3'd0;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
            ctrlen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            fault_q  <= fault_d;
            halted_q <= halted_d;
            ctrlen_q <= ctrlen_d;
        end
    end

    assign uaddr        = {opcode, flags, step_q};
    assign control_word = ctrlen_q ? ((urom_data & KEEP_MASK) | (IDLE_CW & SEQ_MASK))
                                   : IDLE_CW;
    assign ctrlen       = ctrlen_q;
    assign step         = step_q;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Table-driven bench for microcode_sequencer with a behavioural microcode ROM
// whose SR/HLT bits are placed per step by masks chosen in each vector.
module tb_microcode_sequencer;

    localparam logic [31:0] IDLE   = 32'h17FF58FF;
    localparam logic [31:0] SR_M   = 32'h1000_0000;
    localparam logic [31:0] HLT_M  = 32'h2000_0000;
    localparam logic [1:0]  S_I    = 2'd0;
    localparam logic [1:0]  S_R    = 2'd1;
    localparam logic [1:0]  S_H    = 2'd2;

    logic        clk;
    logic        rst;
    logic [7:0]  opcode;
    logic [3:0]  flags;
    logic [31:0] urom_data;
    logic        resume;
    logic        step_req;
    logic [14:0] uaddr;
    logic [31:0] control_word;
    logic        ctrlen;
    logic [2:0]  step;
    logic        halted;
    logic        fault;

    logic [7:0]  sr_mask;
    logic [7:0]  hlt_mask;

    int n_checks = 0;
    int n_fail   = 0;

    microcode_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .flags        (flags),
        .urom_data    (urom_data),
        .resume       (resume),
`ifdef MICROCODE_SEQUENCER_SINGLE_STEP_EN
        .step_req     (step_req),
`endif
        .uaddr        (uaddr),
        .control_word (control_word),
        .ctrlen       (ctrlen),
        .step         (step),
        .halted       (halted),
        .fault        (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [7:0] op, input logic [3:0] fl,
                                             input logic [2:0] s);
        logic [31:0] w;
        w = (32'h8A5C_3300 ^ {8'h00, op, 4'h0, fl, 8'h00}) | {29'd0, s};
        if (sr_mask[s])  w = w | SR_M;
        if (hlt_mask[s]) w = w | HLT_M;
        return w;
    endfunction

    // Behavioural ROM answering whatever address the sequencer presents.
    always_comb urom_data = rom_word(uaddr[14:7], uaddr[6:3], uaddr[2:0]);

    function automatic logic [31:0] exp_cw(input logic [1:0] st, input logic [7:0] op,
                                           input logic [3:0] fl, input logic [2:0] s);
        logic [31:0] w;
        if (st != S_R) return IDLE;
        w = rom_word(op, fl, s);
        w[28] = IDLE[28];
        w[29] = IDLE[29];
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    task automatic check_all(input string nm, input logic [2:0] s, input logic [1:0] st,
                             input logic f);
        chk({nm, " step"},   {29'd0, step},        {29'd0, s});
        chk({nm, " ctrlen"}, {31'd0, ctrlen},      {31'd0, st == S_R});
        chk({nm, " halted"}, {31'd0, halted},      {31'd0, st == S_H});
        chk({nm, " fault"},  {31'd0, fault},       {31'd0, f});
        chk({nm, " uaddr"},  {17'd0, uaddr},       {17'd0, opcode, flags, s});
        chk({nm, " cw"},     control_word,         exp_cw(st, opcode, flags, s));
        $display("%s: rst=%0b op=%h flags=%h step=%0d ctrlen=%0b halted=%0b fault=%0b cw=%h",
                 nm, rst, opcode, flags, step, ctrlen, halted, fault, control_word);
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] op;
        logic [3:0] fl;
        logic [7:0] sr;
        logic [7:0] hlt;
        logic       res;
        logic [2:0] s;
        logic [1:0] st;
        logic       f;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [7:0] op, input logic [3:0] fl,
                                input logic [7:0] sr, input logic [7:0] hlt, input logic res,
                                input logic [2:0] s, input logic [1:0] st, input logic f);
        vec_t v;
        v.rst_n = r; v.op = op; v.fl = fl; v.sr = sr; v.hlt = hlt;
        v.res = res; v.s = s; v.st = st; v.f = f;
        return v;
    endfunction

    initial begin
        rst      = 1'b0;
        opcode   = 8'h05;
        flags    = 4'h0;
        resume   = 1'b0;
        step_req = 1'b1;
        sr_mask  = 8'h04;
        hlt_mask = 8'h00;

        // SR at step 2, resume ignored while running, flag change mid-instruction.
        vecs.push_back(mk(0, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd0, S_I, 0));
        vecs.push_back(mk(0, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd0, S_I, 0));
        vecs.push_back(mk(1, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd0, S_I, 0));
        vecs.push_back(mk(1, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd0, S_R, 0));
        vecs.push_back(mk(1, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd1, S_R, 0));
        vecs.push_back(mk(1, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd2, S_R, 0));
        vecs.push_back(mk(1, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd0, S_R, 0));
        vecs.push_back(mk(1, 8'h05, 4'h4, 8'h04, 8'h00, 0, 3'd1, S_R, 0));
        vecs.push_back(mk(1, 8'h05, 4'h0, 8'h04, 8'h00, 1, 3'd2, S_R, 0));
        vecs.push_back(mk(1, 8'h05, 4'h0, 8'h04, 8'h00, 0, 3'd0, S_R, 0));
        // HLT together with SR at step 1: halt wins, resume restarts at step 0.
        vecs.push_back(mk(0, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd0, S_I, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd0, S_I, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd0, S_R, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd1, S_R, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd0, S_H, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 1, 3'd0, S_H, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd0, S_R, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd1, S_R, 0));
        vecs.push_back(mk(1, 8'hA3, 4'h0, 8'h06, 8'h02, 0, 3'd0, S_H, 0));
        // No SR anywhere: wrap 7->0 sets fault, which survives halt/resume until reset.
        vecs.push_back(mk(0, 8'h3C, 4'h0, 8'h00, 8'h00, 0, 3'd0, S_I, 0));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h00, 0, 3'd0, S_I, 0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h00, 0, k[2:0], S_R, 0));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h02, 0, 3'd0, S_R, 1));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h02, 0, 3'd1, S_R, 1));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h02, 1, 3'd0, S_H, 1));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h02, 0, 3'd0, S_R, 1));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h02, 0, 3'd1, S_R, 1));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h02, 0, 3'd0, S_H, 1));
        vecs.push_back(mk(0, 8'h3C, 4'h0, 8'h00, 8'h00, 0, 3'd0, S_I, 0));
        vecs.push_back(mk(1, 8'h3C, 4'h0, 8'h00, 8'h00, 0, 3'd0, S_I, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst      = vecs[i].rst_n;
            opcode   = vecs[i].op;
            flags    = vecs[i].fl;
            sr_mask  = vecs[i].sr;
            hlt_mask = vecs[i].hlt;
            #1;
            check_all($sformatf("v%0d", i), vecs[i].s, vecs[i].st, vecs[i].f);
            resume = vecs[i].res;
        end

        // Asynchronous reset at step 3, between clock edges.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check_all($sformatf("pre_rst s%0d", k), k[2:0], S_R, 1'b0);
        end
        #2 rst = 1'b0;
        #1 check_all("async_rst", 3'd0, S_I, 1'b0);
        @(negedge clk);
        #1 check_all("rst_hold", 3'd0, S_I, 1'b0);
        rst = 1'b1;
        #1 check_all("rst_release", 3'd0, S_I, 1'b0);
        @(negedge clk);
        #1 check_all("first_edge", 3'd0, S_R, 1'b0);

`ifdef MICROCODE_SEQUENCER_SINGLE_STEP_EN
        step_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 check_all($sformatf("ss_hold%0d", k), 3'd0, S_R, 1'b0);
        end
        step_req = 1'b1;
        @(negedge clk);
        #1 check_all("ss_advance", 3'd1, S_R, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter IDLE_CW, default 32'h17FF58FF, is the all-inactive control word driven whenever the sequencer is not running.
REQ-002 Parameter SR_BIT, default 28, is the microcode bit index meaning "last step, reset step counter" (active-high).
REQ-003 Parameter HLT_BIT, default 29, is the microcode bit index meaning "halt after this step" (active-high).
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 opcode  input  8  current instruction register contents.
REQ-007 flags  input  4  ALU flags {C,Z,N,V}, sampled combinationally into uaddr.
REQ-008 urom_data  input  32  microcode ROM word returned for uaddr, combinational, same cycle.
REQ-009 resume  input  1  leaves HALT when high at a rising clk.
REQ-010 step_req  input  1  single-step advance request; port exists only when SINGLE_STEP_EN is defined.
REQ-011 uaddr  output  15  microcode ROM address {opcode, flags, step}.
REQ-012 control_word  output  32  CPU control word.
REQ-013 ctrlen  output  1  control-word enable for the CPU; high only in RUN.
REQ-014 step  output  3  current microstep.
REQ-015 halted  output  1  high in HALT.
REQ-016 fault  output  1  sticky step-overflow indicator.

Function
REQ-017 The FSM SHALL have states INIT, RUN and HALT.
REQ-018 INIT SHALL go to RUN at the first rising clk after rst deasserts, with step=0.
REQ-019 uaddr SHALL be combinational {opcode, flags, step}; ROM-to-output latency is zero cycles.
REQ-020 In RUN, control_word SHALL equal urom_data with bits SR_BIT and HLT_BIT replaced by the matching IDLE_CW bits.
REQ-021 In INIT and HALT, control_word SHALL equal IDLE_CW and ctrlen SHALL be 0.
REQ-022 In RUN at a rising clk:
- if urom_data[HLT_BIT]=1: go to HALT, step=0;
- else if urom_data[SR_BIT]=1: step=0;
- else if step=7: step=0 and fault=1 (wrap-around without SR);
- else step=step+1.
REQ-023 HLT_BIT SHALL take precedence over SR_BIT when both are set; the halting step is still fully presented for its cycle.
REQ-024 In HALT, resume=1 at a rising clk SHALL go to RUN with step=0; halted SHALL fall in the same cycle.
REQ-025 resume SHALL be ignored in INIT and RUN.
REQ-026 fault SHALL stay set until reset; it SHALL NOT affect sequencing.
REQ-027 Flag changes mid-instruction SHALL change uaddr, and therefore control_word, within the same cycle.

Reset
REQ-028 rst low SHALL immediately set state=INIT, step=0, halted=0, fault=0, control_word=IDLE_CW and ctrlen=0, including in the middle of an instruction.
REQ-029 While rst is low, the outputs SHALL hold these values regardless of clk or any other input.

Configuration
REQ-030 With MICROCODE_SEQUENCER_SINGLE_STEP_EN defined, step_req SHALL exist and the RUN transitions in REQ-022 SHALL occur only on rising edges where step_req=1; otherwise state and step SHALL hold and control_word SHALL stay stable.
REQ-031 Without MICROCODE_SEQUENCER_SINGLE_STEP_EN, step_req SHALL be absent and every rising clk in RUN SHALL advance per REQ-022.

Verification
REQ-032 Reset release, opcode=8'h05, ROM word at step 2 has SR set -> step sequence 0,1,2,0; ctrlen=1 from the first edge; control_word equals ROM data with SR_BIT forced to IDLE_CW[28].
REQ-033 ROM word at step 1 has HLT set -> halted=1, control_word=32'h17FF58FF, ctrlen=0; resume pulse -> RUN with step=0 on the next edge.
REQ-034 ROM returns no SR for 8 steps -> step wraps 7 to 0 and fault=1; fault stays 1 through HALT/resume and clears only on rst low.
REQ-035 rst asserted at step 3 between clock edges -> outputs go to reset values without a clock edge; first edge after release -> RUN, step=0.
REQ-036 flags change from 4'b0000 to 4'b0100 at step 1 -> uaddr changes from {op,0,1} to {op,4,1} in the same cycle; step is unaffected.
REQ-037 With MICROCODE_SEQUENCER_SINGLE_STEP_EN defined, 5 clocks with step_req=0 then 1 clock with step_req=1 -> step holds at 0, then advances to 1.
